// File: rtl/jesd204_tx_link_ctrl.sv
// JESD204B TX link sequencer for one 4-octet lane: CGS, then ILAS, then user data, with SYNC~ resync and error counting.
// Latency: every output is registered, so tx_data carries the word chosen by the previous cycle's state and counters.
// Backpressure: none; data_in is taken on every DATA cycle (data_ready high), and SYNC~ low restarts the sequence at CGS.
module jesd204_tx_link_ctrl #(
    parameter int BEATS_PER_MF     = 8,
    parameter int ILAS_MULTIFRAMES = 4,
    parameter int SCRAMBLE         = 1,
    parameter int RESYNC_CYCLES    = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        sysref,
    input  logic        sync_n,
    input  logic [31:0] data_in,
    output logic        data_ready,
    output logic [1:0]  ilas_cfg_addr,
    input  logic [31:0] ilas_cfg_data,
    output logic [31:0] tx_data,
    output logic [3:0]  tx_charisk,
    output logic        scr_enable,
    output logic        lmfc_edge,
    output logic [1:0]  state_o,
    output logic [7:0]  err_count
);

    localparam int LW = $clog2(BEATS_PER_MF);
    localparam int MW = (ILAS_MULTIFRAMES > 1) ? $clog2(ILAS_MULTIFRAMES) : 1;
    localparam int RW = $clog2(RESYNC_CYCLES + 1);
    localparam logic [LW-1:0] LAST_BEAT = LW'(BEATS_PER_MF - 1);
    localparam logic [MW-1:0] LAST_MF   = MW'(ILAS_MULTIFRAMES - 1);
    localparam logic [RW-1:0] RESYNC_AT = RW'(RESYNC_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CGS  = 2'd1,
        ST_ILAS = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [LW-1:0] lmfc_cnt, lmfc_nxt;
    logic [LW-1:0] beat;
    logic [MW-1:0] mf;
    logic [RW-1:0] low_cnt;
    logic          in_link, resync, err_pulse, ilas_last;
    logic [31:0]   ilas_word;
    logic [3:0]    ilas_k;

    assign state_o   = state;
    assign in_link   = (state == ST_ILAS) || (state == ST_DATA);
    assign resync    = in_link && !sync_n && (low_cnt == RESYNC_AT);
    assign err_pulse = in_link && enable && sync_n && (low_cnt != '0);
    assign ilas_last = (beat == LAST_BEAT) && (mf == LAST_MF);

    always_comb begin
        lmfc_nxt = lmfc_cnt + 1'b1;
        if (sysref || (lmfc_cnt == LAST_BEAT)) begin
            lmfc_nxt = '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enable) state_nxt = ST_CGS;
            // Leave CGS so that the first ILAS beat lands on LMFC count 0.
            ST_CGS:  if (sync_n && (lmfc_nxt == '0)) state_nxt = ST_ILAS;
            ST_ILAS: begin
                if (resync) begin
                    state_nxt = ST_CGS;
                end else if (ilas_last) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: if (resync) state_nxt = ST_CGS;
            default: state_nxt = ST_IDLE;
        endcase
        if (!enable) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        ilas_word = '0;
        ilas_k    = '0;
        for (int i = 0; i < 4; i++) begin
            ilas_word[8*i +: 8] = 8'({beat, 2'(i)});
        end
        if (beat == '0) begin
            ilas_word[7:0] = 8'h1C;
            ilas_k[0]      = 1'b1;
        end
        if (beat == LAST_BEAT) begin
            ilas_word[31:24] = 8'h7C;
            ilas_k[3]        = 1'b1;
        end
        if (mf == MW'(1)) begin
            if (beat == '0) begin
                ilas_word[15:8] = 8'h9C;
                ilas_k[1]       = 1'b1;
            end else if (beat <= LW'(4)) begin
                ilas_word = ilas_cfg_data;
                ilas_k    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            lmfc_cnt      <= '0;
            lmfc_edge     <= 1'b1;
            beat          <= '0;
            mf            <= '0;
            low_cnt       <= '0;
            err_count     <= '0;
            ilas_cfg_addr <= '0;
            data_ready    <= 1'b0;
            scr_enable    <= 1'b0;
            tx_data       <= 32'hBCBC_BCBC;
            tx_charisk    <= 4'hF;
        end else begin
            state      <= state_nxt;
            lmfc_cnt   <= lmfc_nxt;
            lmfc_edge  <= (lmfc_nxt == '0);
            data_ready <= (state_nxt == ST_DATA);

            // ILAS beat counters run independently of the LMFC so sysref cannot restart ILAS.
            if ((state == ST_ILAS) && (state_nxt == ST_ILAS)) begin
                if (beat == LAST_BEAT) begin
                    beat <= '0;
                    mf   <= mf + 1'b1;
                end else begin
                    beat <= beat + 1'b1;
                end
            end else begin
                beat <= '0;
                mf   <= '0;
            end

            if (in_link && !sync_n &&
                ((state_nxt == ST_ILAS) || (state_nxt == ST_DATA))) begin
                low_cnt <= low_cnt + 1'b1;
            end else begin
                low_cnt <= '0;
            end

            if (err_pulse && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end

            // Present the config address one cycle ahead so the lookup is ready on beats 1..4.
            if ((state == ST_ILAS) && (state_nxt == ST_ILAS) &&
                (mf == MW'(1)) && (beat < LW'(4))) begin
                ilas_cfg_addr <= beat[1:0];
            end else begin
                ilas_cfg_addr <= '0;
            end

            scr_enable <= (SCRAMBLE != 0) && (state == ST_DATA);
            case (state)
                ST_ILAS: begin
                    tx_data    <= ilas_word;
                    tx_charisk <= ilas_k;
                end
                ST_DATA: begin
                    tx_data    <= data_in;
                    tx_charisk <= 4'h0;
                end
                default: begin
                    tx_data    <= 32'hBCBC_BCBC;
                    tx_charisk <= 4'hF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jesd204_tx_link_ctrl.sv
// Bench for jesd204_tx_link_ctrl: table of expected ILAS words and a DATA-phase vector table, with a queue scoreboard for tx outputs.
module tb_jesd204_tx_link_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic        sysref;
    logic        sync_n;
    logic [31:0] data_in;
    logic        data_ready;
    logic [1:0]  ilas_cfg_addr;
    logic [31:0] ilas_cfg_data;
    logic [31:0] tx_data;
    logic [3:0]  tx_charisk;
    logic        scr_enable;
    logic        lmfc_edge;
    logic [1:0]  state_o;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    assign ilas_cfg_data = 32'hA000_0000 + {30'd0, ilas_cfg_addr};

    jesd204_tx_link_ctrl #(
        .BEATS_PER_MF(8), .ILAS_MULTIFRAMES(4), .SCRAMBLE(1), .RESYNC_CYCLES(4)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .sysref(sysref), .sync_n(sync_n),
        .data_in(data_in), .data_ready(data_ready), .ilas_cfg_addr(ilas_cfg_addr),
        .ilas_cfg_data(ilas_cfg_data), .tx_data(tx_data), .tx_charisk(tx_charisk),
        .scr_enable(scr_enable), .lmfc_edge(lmfc_edge), .state_o(state_o),
        .err_count(err_count)
    );

    typedef struct {
        logic [31:0] dat;
        logic [3:0]  k;
        logic        scr;
    } exp_t;

    typedef struct {
        logic        sync;
        logic [31:0] din;
        logic [1:0]  st;
        logic        rdy;
        logic [7:0]  err;
    } vec_t;

    exp_t ilas_tbl[32];
    vec_t vtab[13];
    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic s);
        exp_t e;
        e.dat = d;
        e.k   = k;
        e.scr = s;
        q.push_back(e);
    endtask

    task automatic push_idle();
        push(32'hBCBC_BCBC, 4'hF, 1'b0);
    endtask

    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("tx_data", tx_data, e.dat);
            chk("tx_charisk", 32'(tx_charisk), 32'(e.k));
            chk("scr_enable", 32'(scr_enable), 32'(e.scr));
        end
    endtask

    // which: 0 waits for state ILAS, 1 waits for lmfc_edge; only used while outputs are K28.5.
    task automatic wait_for(input int which, input int max, input string name);
        bit hit = 0;
        for (int n = 0; n < max && !hit; n++) begin
            push_idle();
            cycle();
            hit = (which == 0) ? (state_o == 2'd2) : (lmfc_edge == 1'b1);
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL %s: timeout after %0d cycles", name, max);
        end
    endtask

    task automatic set_vec(input int i, input logic s, input logic [1:0] st,
                           input logic rdy, input logic [7:0] err);
        vtab[i].sync = s;
        vtab[i].din  = 32'h1122_3344 + i;
        vtab[i].st   = st;
        vtab[i].rdy  = rdy;
        vtab[i].err  = err;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] prev_st;

        for (int m = 0; m < 4; m++) begin
            for (int b = 0; b < 8; b++) begin
                for (int i = 0; i < 4; i++) begin
                    ilas_tbl[m*8+b].dat[8*i +: 8] = 8'((b*4 + i) % 256);
                    ilas_tbl[m*8+b].k[i] = 1'b0;
                end
                ilas_tbl[m*8+b].scr = 1'b0;
                if (b == 0) begin
                    ilas_tbl[m*8+b].dat[7:0] = 8'h1C;
                    ilas_tbl[m*8+b].k[0]     = 1'b1;
                end
                if (b == 7) begin
                    ilas_tbl[m*8+b].dat[31:24] = 8'h7C;
                    ilas_tbl[m*8+b].k[3]       = 1'b1;
                end
                if (m == 1 && b == 0) begin
                    ilas_tbl[m*8+b].dat[15:8] = 8'h9C;
                    ilas_tbl[m*8+b].k[1]      = 1'b1;
                end
                if (m == 1 && b >= 1 && b <= 4) begin
                    ilas_tbl[m*8+b].dat = 32'hA000_0000 + 32'(b - 1);
                    ilas_tbl[m*8+b].k   = 4'h0;
                end
            end
        end

        // DATA phase: short low run (error), then a 4-cycle low run forcing CGS.
        set_vec(0,  1'b1, 2'd3, 1'b1, 8'd0);
        set_vec(1,  1'b1, 2'd3, 1'b1, 8'd0);
        set_vec(2,  1'b1, 2'd3, 1'b1, 8'd0);
        set_vec(3,  1'b0, 2'd3, 1'b1, 8'd0);
        set_vec(4,  1'b0, 2'd3, 1'b1, 8'd0);
        set_vec(5,  1'b1, 2'd3, 1'b1, 8'd1);
        set_vec(6,  1'b1, 2'd3, 1'b1, 8'd1);
        set_vec(7,  1'b0, 2'd3, 1'b1, 8'd1);
        set_vec(8,  1'b0, 2'd3, 1'b1, 8'd1);
        set_vec(9,  1'b0, 2'd3, 1'b1, 8'd1);
        set_vec(10, 1'b0, 2'd1, 1'b0, 8'd1);
        set_vec(11, 1'b0, 2'd1, 1'b0, 8'd1);
        set_vec(12, 1'b0, 2'd1, 1'b0, 8'd1);

        resetn  = 1'b0;
        enable  = 1'b0;
        sysref  = 1'b0;
        sync_n  = 1'b0;
        data_in = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst tx_data", tx_data, 32'hBCBC_BCBC);
        chk("rst tx_charisk", 32'(tx_charisk), 32'hF);
        chk("rst scr_enable", 32'(scr_enable), 32'd0);
        chk("rst state", 32'(state_o), 32'd0);
        chk("rst data_ready", 32'(data_ready), 32'd0);
        chk("rst err_count", 32'(err_count), 32'd0);
        chk("rst cfg_addr", 32'(ilas_cfg_addr), 32'd0);
        chk("rst lmfc_edge", 32'(lmfc_edge), 32'd1);
        resetn = 1'b1;

        push_idle();
        cycle();
        chk("idle state", 32'(state_o), 32'd0);

        wait_for(1, 10, "lmfc edge");
        push_idle();
        cycle();
        chk("lmfc off-edge", 32'(lmfc_edge), 32'd0);
        repeat (7) begin
            push_idle();
            cycle();
        end
        chk("lmfc period", 32'(lmfc_edge), 32'd1);

        enable = 1'b1;
        push_idle();
        cycle();
        chk("cgs entry", 32'(state_o), 32'd1);
        repeat (20) begin
            push_idle();
            cycle();
        end
        chk("cgs hold", 32'(state_o), 32'd1);

        sync_n = 1'b1;
        wait_for(0, 12, "ilas entry");
        chk("ilas on lmfc", 32'(lmfc_edge), 32'd1);
        for (int k = 0; k < 32; k++) begin
            push(ilas_tbl[k].dat, ilas_tbl[k].k, 1'b0);
            cycle();
            if (k == 0) chk("ilas first word", tx_data, 32'h0302_011C);
            if (k == 7) chk("ilas last beat", tx_data, 32'h7C1E_1D1C);
            if (k == 7) chk("ilas last k", 32'(tx_charisk), 32'h8);
            if (k == 8) chk("ilas mf1 beat0", tx_data, 32'h0302_9C1C);
            if (k == 12) chk("ilas cfg word3", tx_data, 32'hA000_0003);
        end
        chk("data state", 32'(state_o), 32'd3);
        chk("data ready", 32'(data_ready), 32'd1);
        chk("data lmfc aligned", 32'(lmfc_edge), 32'd1);

        prev_st = 2'd3;
        for (int r = 0; r < 13; r++) begin
            sync_n  = vtab[r].sync;
            data_in = vtab[r].din;
            if (prev_st == 2'd3) push(vtab[r].din, 4'h0, 1'b1);
            else                 push_idle();
            cycle();
            chk($sformatf("vec%0d state", r), 32'(state_o), 32'(vtab[r].st));
            chk($sformatf("vec%0d ready", r), 32'(data_ready), 32'(vtab[r].rdy));
            chk($sformatf("vec%0d err", r), 32'(err_count), 32'(vtab[r].err));
            prev_st = vtab[r].st;
        end

        // sysref at LMFC count 5 while held in CGS.
        wait_for(1, 10, "cgs lmfc edge");
        repeat (5) begin
            push_idle();
            cycle();
        end
        chk("lmfc at 5", 32'(lmfc_edge), 32'd0);
        sysref = 1'b1;
        push_idle();
        cycle();
        sysref = 1'b0;
        chk("sysref realign", 32'(lmfc_edge), 32'd1);
        push_idle();
        cycle();
        chk("after realign", 32'(lmfc_edge), 32'd0);
        repeat (7) begin
            push_idle();
            cycle();
        end
        chk("realigned period", 32'(lmfc_edge), 32'd1);

        // Second ILAS: sysref mid-sequence must not restart it; then disable.
        sync_n = 1'b1;
        wait_for(0, 12, "ilas re-entry");
        chk("ilas2 on lmfc", 32'(lmfc_edge), 32'd1);
        for (int k = 0; k < 11; k++) begin
            sysref = (k == 3);
            push(ilas_tbl[k].dat, ilas_tbl[k].k, 1'b0);
            cycle();
            if (k == 3) chk("ilas sysref edge", 32'(lmfc_edge), 32'd1);
        end
        sysref = 1'b0;
        enable = 1'b0;
        push(ilas_tbl[11].dat, ilas_tbl[11].k, 1'b0);
        cycle();
        chk("disable state", 32'(state_o), 32'd0);
        chk("disable err kept", 32'(err_count), 32'd1);
        chk("disable ready", 32'(data_ready), 32'd0);
        push_idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
